// File: rtl/vga_pixel_sink_if.sv
// Pixel-sink bus: coordinates out to drawing units,
// composited colour in, DAC/sync out to the display.
interface vga_pixel_sink_if;
  logic [7:0]  RGBIn;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic [3:0]  oVGA_R;
  logic [3:0]  oVGA_G;
  logic [3:0]  oVGA_B;
  logic        oVGA_HS;
  logic        oVGA_VS;
  logic        oVGA_BLANK_N;

  modport master (
    input  RGBIn,
    output pixelX, pixelY, startOfFrame,
    output oVGA_R, oVGA_G, oVGA_B,
    output oVGA_HS, oVGA_VS, oVGA_BLANK_N
  );

  modport slave (
    output RGBIn,
    input  pixelX, pixelY, startOfFrame,
    input  oVGA_R, oVGA_G, oVGA_B,
    input  oVGA_HS, oVGA_VS, oVGA_BLANK_N
  );
endinterface

// File: rtl/vga_pixel_sink.sv
// VGA raster generator and display-side pixel sink:
// counts, sync/blank alignment, RRRGGGBB to 4:4:4 expansion.
module vga_pixel_sink #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic              clk,
  input  logic              resetN,
  vga_pixel_sink_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [10:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic        r_run;
  logic        r_sof;

  logic [10:0] w_hnext;
  logic [10:0] w_vnext;
  logic        w_hwrap;
  logic        w_vwrap;
  logic        w_active;
  logic        w_hs_n;
  logic        w_vs_n;

  logic [PIPE_DELAY-1:0] r_act_d;
  logic [PIPE_DELAY-1:0] r_hs_d;
  logic [PIPE_DELAY-1:0] r_vs_d;

  logic [3:0] r_r;
  logic [3:0] r_g;
  logic [3:0] r_b;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank_n;

  assign w_hwrap = (r_hcnt == 11'(H_TOTAL - 1));
  assign w_vwrap = (r_vcnt == 11'(V_TOTAL - 1));

  // First edge after reset holds (0,0) so startOfFrame can pulse there.
  always_comb begin
    w_hnext = r_hcnt;
    w_vnext = r_vcnt;
    if (r_run) begin
      w_hnext = w_hwrap ? 11'd0 : r_hcnt + 11'd1;
      if (w_hwrap)
        w_vnext = w_vwrap ? 11'd0 : r_vcnt + 11'd1;
    end
  end

  assign w_active = (r_hcnt < 11'(H_ACTIVE))
                 && (r_vcnt < 11'(V_ACTIVE));
  assign w_hs_n = !((r_hcnt >= 11'(H_ACTIVE + H_FP))
               && (r_hcnt < 11'(H_ACTIVE + H_FP + H_SYNC)));
  assign w_vs_n = !((r_vcnt >= 11'(V_ACTIVE + V_FP))
               && (r_vcnt < 11'(V_ACTIVE + V_FP + V_SYNC)));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
      r_run  <= 1'b0;
      r_sof  <= 1'b0;
    end else begin
      r_hcnt <= w_hnext;
      r_vcnt <= w_vnext;
      r_run  <= 1'b1;
      r_sof  <= (w_hnext == 11'd0) && (w_vnext == 11'd0);
    end
  end

  // Decode is ignored during the hold edge so (0,0) is emitted once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_act_d <= '0;
      r_hs_d  <= '1;
      r_vs_d  <= '1;
    end else begin
      r_act_d[0] <= r_run & w_active;
      r_hs_d[0]  <= ~r_run | w_hs_n;
      r_vs_d[0]  <= ~r_run | w_vs_n;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        r_act_d[i] <= r_act_d[i-1];
        r_hs_d[i]  <= r_hs_d[i-1];
        r_vs_d[i]  <= r_vs_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_hs      <= r_hs_d[PIPE_DELAY-1];
      r_vs      <= r_vs_d[PIPE_DELAY-1];
      r_blank_n <= r_act_d[PIPE_DELAY-1];
      if (r_act_d[PIPE_DELAY-1]) begin
        r_r <= {bus.RGBIn[7:5], bus.RGBIn[7]};
        r_g <= {bus.RGBIn[4:2], bus.RGBIn[4]};
        r_b <= {bus.RGBIn[1:0], bus.RGBIn[1:0]};
      end else begin
        r_r <= '0;
        r_g <= '0;
        r_b <= '0;
      end
    end
  end

  assign bus.pixelX       = r_hcnt;
  assign bus.pixelY       = r_vcnt;
  assign bus.startOfFrame = r_sof;
  assign bus.oVGA_R       = r_r;
  assign bus.oVGA_G       = r_g;
  assign bus.oVGA_B       = r_b;
  assign bus.oVGA_HS      = r_hs;
  assign bus.oVGA_VS      = r_vs;
  assign bus.oVGA_BLANK_N = r_blank_n;

endmodule
